// File: rtl/box_cmd_parser.sv
// Parses overlay-box command packets from a UDP RX byte stream into per-box bounds, colour and enable.
// Define BOX_CMD_CHECKSUM_EN to append a 14th byte holding the XOR of bytes 0-12.
module box_cmd_parser #(
    parameter int unsigned N_BOX = 2,
    parameter int unsigned H_ACT = 1280,
    parameter int unsigned V_ACT = 720
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 valid,
    input  logic [7:0]           i_data,
    input  logic [15:0]          data_len,
    output logic [N_BOX*11-1:0]  start_xs,
    output logic [N_BOX*11-1:0]  end_xs,
    output logic [N_BOX*10-1:0]  start_ys,
    output logic [N_BOX*10-1:0]  end_ys,
    output logic [N_BOX*24-1:0]  colors,
    output logic [N_BOX-1:0]     box_en,
    output logic                 updated,
    output logic                 cmd_err
);

`ifdef BOX_CMD_CHECKSUM_EN
    localparam int unsigned L = 14;
`else
    localparam int unsigned L = 13;
`endif
    localparam logic [3:0] LAST = 4'(L - 1);

    typedef enum logic [1:0] {StIdle, StBody, StDrain, StCommit} state_t;

    state_t              r_state, w_state_nxt;
    logic                r_valid_prev;
    logic [3:0]          r_cnt;
    logic [7:0]          r_idx;
    logic [10:0]         r_sx, r_ex;
    logic [9:0]          r_sy, r_ey;
    logic [23:0]         r_rgb;
    logic                r_err_pend, r_cmd_err, r_updated;
    logic [N_BOX*11-1:0] r_start_xs, r_end_xs;
    logic [N_BOX*10-1:0] r_start_ys, r_end_ys;
    logic [N_BOX*24-1:0] r_colors;
    logic [N_BOX-1:0]    r_box_en;
    logic                w_start, w_take, w_ok, w_fail;
    logic [10:0]         w_ex;
    logic [9:0]          w_ey;
`ifdef BOX_CMD_CHECKSUM_EN
    logic [7:0]          r_xor;
`endif

    // Sampled even in reset so a packet still streaming through reset cannot look like a start.
    always_ff @(posedge clk) r_valid_prev <= valid;

    assign w_start = valid & ~r_valid_prev;
    assign w_ex    = {r_ex[10:8], i_data};
    assign w_ey    = {r_ey[9:8], i_data};

    // Per-byte acceptance check; r_cnt is the position of the byte on i_data.
    always_comb begin
        w_ok = 1'b1;
        case (r_cnt)
            4'd0:       w_ok = (i_data == 8'hA5) && (data_len == 16'(L));
            4'd1:       w_ok = (32'(i_data) < N_BOX) || (i_data == 8'hFF);
            4'd2, 4'd6: w_ok = (i_data[7:3] == 5'd0);
            4'd4, 4'd8: w_ok = (i_data[7:2] == 6'd0);
            4'd7:       w_ok = (r_sx <= w_ex) && (32'(w_ex) < H_ACT);
            4'd9:       w_ok = (r_sy <= w_ey) && (32'(w_ey) < V_ACT);
`ifdef BOX_CMD_CHECKSUM_EN
            4'd13:      w_ok = (i_data == r_xor);
`endif
            default:    w_ok = 1'b1;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_take      = 1'b0;
        w_fail      = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_start) begin
                    w_take = 1'b1;
                    if (w_ok) begin
                        w_state_nxt = StBody;
                    end else begin
                        w_state_nxt = StDrain;
                        w_fail      = 1'b1;
                    end
                end
            end
            StBody: begin
                // Early fall: valid is already low, so skip DRAIN and allow an immediate restart.
                if (!valid) begin
                    w_state_nxt = StIdle;
                    w_fail      = 1'b1;
                end else begin
                    w_take = 1'b1;
                    if (!w_ok) begin
                        w_state_nxt = StDrain;
                        w_fail      = 1'b1;
                    end else if (r_cnt == LAST) begin
                        w_state_nxt = StCommit;
                    end
                end
            end
            StDrain:  if (!valid) w_state_nxt = StIdle;
            StCommit: w_state_nxt = StIdle;
            default:  w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state    <= StIdle;
            r_cnt      <= 4'd0;
            r_err_pend <= 1'b0;
            r_cmd_err  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= (w_state_nxt == StBody) ? r_cnt + 4'd1 : 4'd0;
            r_err_pend <= w_fail;
            r_cmd_err  <= r_err_pend;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_idx <= 8'd0;
            r_sx  <= 11'd0;
            r_ex  <= 11'd0;
            r_sy  <= 10'd0;
            r_ey  <= 10'd0;
            r_rgb <= 24'd0;
        end else if (w_take) begin
            case (r_cnt)
                4'd1:    r_idx         <= i_data;
                4'd2:    r_sx[10:8]    <= i_data[2:0];
                4'd3:    r_sx[7:0]     <= i_data;
                4'd4:    r_sy[9:8]     <= i_data[1:0];
                4'd5:    r_sy[7:0]     <= i_data;
                4'd6:    r_ex[10:8]    <= i_data[2:0];
                4'd7:    r_ex[7:0]     <= i_data;
                4'd8:    r_ey[9:8]     <= i_data[1:0];
                4'd9:    r_ey[7:0]     <= i_data;
                4'd10:   r_rgb[23:16]  <= i_data;
                4'd11:   r_rgb[15:8]   <= i_data;
                4'd12:   r_rgb[7:0]    <= i_data;
                default: ;
            endcase
        end
    end

`ifdef BOX_CMD_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_xor <= 8'd0;
        end else if (w_take) begin
            r_xor <= (r_cnt == 4'd0) ? i_data : (r_xor ^ i_data);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_start_xs <= '0;
            r_end_xs   <= '0;
            r_start_ys <= '0;
            r_end_ys   <= '0;
            r_colors   <= '0;
            r_box_en   <= '0;
            r_updated  <= 1'b0;
        end else begin
            r_updated <= 1'b0;
            if (r_state == StCommit) begin
                r_updated <= 1'b1;
                if (r_idx == 8'hFF) begin
                    r_box_en <= '0;
                end else begin
                    for (int i = 0; i < N_BOX; i++) begin
                        if (r_idx == 8'(i)) begin
                            r_start_xs[i*11 +: 11] <= r_sx;
                            r_end_xs[i*11 +: 11]   <= r_ex;
                            r_start_ys[i*10 +: 10] <= r_sy;
                            r_end_ys[i*10 +: 10]   <= r_ey;
                            r_colors[i*24 +: 24]   <= r_rgb;
                            r_box_en[i]            <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign start_xs = r_start_xs;
    assign end_xs   = r_end_xs;
    assign start_ys = r_start_ys;
    assign end_ys   = r_end_ys;
    assign colors   = r_colors;
    assign box_en   = r_box_en;
    assign updated  = r_updated;
    assign cmd_err  = r_cmd_err;

endmodule

// File: tb/tb_box_cmd_parser.sv
// Scoreboard bench for box_cmd_parser: each packet pushes its expected pulse, timing and
// resulting output state; a negedge monitor pops and compares on every updated/cmd_err pulse.
module tb_box_cmd_parser;

    localparam int NB = 2;
    localparam int H  = 1280;
    localparam int V  = 720;
`ifdef BOX_CMD_CHECKSUM_EN
    localparam int L = 14;
`else
    localparam int L = 13;
`endif

    logic             clk = 1'b0;
    logic             rstn, valid;
    logic [7:0]       i_data;
    logic [15:0]      data_len;
    logic [NB*11-1:0] start_xs, end_xs;
    logic [NB*10-1:0] start_ys, end_ys;
    logic [NB*24-1:0] colors;
    logic [NB-1:0]    box_en;
    logic             updated, cmd_err;

    box_cmd_parser #(.N_BOX(NB), .H_ACT(H), .V_ACT(V)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .valid    (valid),
        .i_data   (i_data),
        .data_len (data_len),
        .start_xs (start_xs),
        .end_xs   (end_xs),
        .start_ys (start_ys),
        .end_ys   (end_ys),
        .colors   (colors),
        .box_en   (box_en),
        .updated  (updated),
        .cmd_err  (cmd_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit               upd;
        int               cyc;
        logic [NB-1:0]    en;
        logic [NB*11-1:0] sxs, exs;
        logic [NB*10-1:0] sys, eys;
        logic [NB*24-1:0] col;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    logic [7:0]       pkt [0:19];
    logic [NB-1:0]    m_en  = '0;
    logic [NB*11-1:0] m_sxs = '0, m_exs = '0;
    logic [NB*10-1:0] m_sys = '0, m_eys = '0;
    logic [NB*24-1:0] m_col = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] req);
        n_cmp++;
        if (got !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, req);
        end
    endtask

    task automatic build(input logic [7:0] idx, input logic [15:0] sx, input logic [15:0] sy,
                         input logic [15:0] ex, input logic [15:0] ey, input logic [23:0] rgb);
        pkt[0]  = 8'hA5;      pkt[1]  = idx;
        pkt[2]  = sx[15:8];   pkt[3]  = sx[7:0];
        pkt[4]  = sy[15:8];   pkt[5]  = sy[7:0];
        pkt[6]  = ex[15:8];   pkt[7]  = ex[7:0];
        pkt[8]  = ey[15:8];   pkt[9]  = ey[7:0];
        pkt[10] = rgb[23:16]; pkt[11] = rgb[15:8]; pkt[12] = rgb[7:0];
        pkt[13] = 8'h00;
        for (int k = 0; k < 13; k++) pkt[13] = pkt[13] ^ pkt[k];
        for (int k = 14; k < 20; k++) pkt[k] = 8'h5A;
    endtask

    // Position of the byte whose sampling decides rejection, or -1 if the packet commits.
    function automatic int fail_pos(input int n, input int len);
        logic [15:0] sx, sy, ex, ey;
        logic [7:0]  x;
        int          lim;
        sx  = {pkt[2], pkt[3]};
        sy  = {pkt[4], pkt[5]};
        ex  = {pkt[6], pkt[7]};
        ey  = {pkt[8], pkt[9]};
        x   = 8'h00;
        for (int k = 0; k < 13; k++) x = x ^ pkt[k];
        lim = (n < L) ? n : L;
        for (int k = 0; k < lim; k++) begin
            if (k == 0 && (len != L || pkt[0] != 8'hA5)) return 0;
            if (k == 1 && !(int'(pkt[1]) < NB || pkt[1] == 8'hFF)) return 1;
            if (k == 2 && sx > 16'd2047) return 2;
            if (k == 4 && sy > 16'd1023) return 4;
            if (k == 6 && ex > 16'd2047) return 6;
            if (k == 7 && (int'(ex) >= H || sx > ex)) return 7;
            if (k == 8 && ey > 16'd1023) return 8;
            if (k == 9 && (int'(ey) >= V || sy > ey)) return 9;
            if (k == 13 && pkt[13] != x) return 13;
        end
        if (n < L) return n;
        return -1;
    endfunction

    task automatic apply_commit();
        int i;
        i = int'(pkt[1]);
        if (pkt[1] == 8'hFF) begin
            m_en = '0;
        end else begin
            m_sxs[i*11 +: 11] = {pkt[2][2:0], pkt[3]};
            m_sys[i*10 +: 10] = {pkt[4][1:0], pkt[5]};
            m_exs[i*11 +: 11] = {pkt[6][2:0], pkt[7]};
            m_eys[i*10 +: 10] = {pkt[8][1:0], pkt[9]};
            m_col[i*24 +: 24] = {pkt[10], pkt[11], pkt[12]};
            m_en[i]           = 1'b1;
        end
    endtask

    // Drive n bytes of pkt with the given length field; rst_at >= 0 pulses rstn low for two bytes.
    task automatic send(input int n, input int len, input int rst_at);
        exp_t e;
        int   fp;
        fp = fail_pos(n, len);
        @(negedge clk);
        if (rst_at < 0) begin
            if (fp < 0) begin
                apply_commit();
                e.upd = 1'b1;
                e.cyc = cyc + L + 1;
            end else begin
                e.upd = 1'b0;
                e.cyc = cyc + fp + 2;
            end
            e.en = m_en; e.sxs = m_sxs; e.exs = m_exs;
            e.sys = m_sys; e.eys = m_eys; e.col = m_col;
            sb.push_back(e);
        end
        for (int k = 0; k < n; k++) begin
            if (k > 0) @(negedge clk);
            if (rst_at >= 0 && k == rst_at) begin
                rstn  = 1'b0;
                m_en  = '0; m_sxs = '0; m_exs = '0;
                m_sys = '0; m_eys = '0; m_col = '0;
            end
            if (rst_at >= 0 && k == rst_at + 2) begin
                rstn = 1'b1;
                check("rst_box_en", 64'(box_en), 64'(m_en));
                check("rst_start_xs", 64'(start_xs), 64'(m_sxs));
                check("rst_end_ys", 64'(end_ys), 64'(m_eys));
                check("rst_colors", 64'(colors), 64'(m_col));
            end
            valid    = 1'b1;
            i_data   = pkt[k];
            data_len = 16'(len);
        end
        @(negedge clk);
        valid  = 1'b0;
        i_data = 8'h00;
        repeat (5) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (updated || cmd_err) begin
            check("pulse_exclusive", 64'(updated & cmd_err), 64'd0);
            if (sb.size() == 0) begin
                check("spurious_pulse", 64'({updated, cmd_err}), 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("pulse_is_updated", 64'(updated), 64'(e.upd));
                check("pulse_cycle", 64'(cyc), 64'(e.cyc));
                check("box_en", 64'(box_en), 64'(e.en));
                check("start_xs", 64'(start_xs), 64'(e.sxs));
                check("end_xs", 64'(end_xs), 64'(e.exs));
                check("start_ys", 64'(start_ys), 64'(e.sys));
                check("end_ys", 64'(end_ys), 64'(e.eys));
                check("colors", 64'(colors), 64'(e.col));
            end
        end
    end

    initial begin
        rstn     = 1'b0;
        valid    = 1'b0;
        i_data   = 8'h00;
        data_len = 16'h0000;
        repeat (3) @(negedge clk);
        check("reset_box_en", 64'(box_en), 64'd0);
        check("reset_start_xs", 64'(start_xs), 64'd0);
        check("reset_end_xs", 64'(end_xs), 64'd0);
        check("reset_start_ys", 64'(start_ys), 64'd0);
        check("reset_end_ys", 64'(end_ys), 64'd0);
        check("reset_colors", 64'(colors), 64'd0);
        check("reset_updated", 64'(updated), 64'd0);
        check("reset_cmd_err", 64'(cmd_err), 64'd0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // Reference packet: box0 (100,100)-(300,300) red
        build(8'd0, 16'd100, 16'd100, 16'd300, 16'd300, 24'hFF0000);
        send(L, L, -1);
        check("ref_sx0", 64'(start_xs[10:0]), 64'd100);
        check("ref_ey0", 64'(end_ys[9:0]), 64'd300);
        check("ref_color0", 64'(colors[23:0]), 64'hFF0000);
        check("ref_en", 64'(box_en), 64'd1);

        build(8'd0, 16'd100, 16'd100, 16'h0500, 16'd300, 24'hFF0000);   // ex == H_ACT
        send(L, L, -1);
        build(8'd1, 16'd20, 16'd30, 16'd40, 16'd50, 24'h00FF00);
        send(8, L, -1);                                                 // valid falls after byte 7
        send(L, L, -1);
        build(8'd1, 16'd1279, 16'd719, 16'd1279, 16'd719, 24'h0000FF);   // max corner, extra bytes
        send(L + 3, L, -1);
        build(8'd0, 16'd1, 16'd2, 16'd3, 16'd4, 24'h123456);
        send(L, L + 1, -1);                                             // bad data_len
        pkt[0] = 8'h5A;
        send(L, L, -1);                                                 // bad magic
        build(8'd2, 16'd1, 16'd2, 16'd3, 16'd4, 24'h123456);
        send(L, L, -1);                                                 // index out of range
        build(8'd0, 16'd10, 16'h0400, 16'd20, 16'h0401, 24'h111111);
        send(L, L, -1);                                                 // sy upper bits set
        build(8'd1, 16'd500, 16'd10, 16'd400, 16'd20, 24'h222222);
        send(L, L, -1);                                                 // sx > ex
        build(8'd0, 16'd0, 16'd0, 16'd10, 16'd720, 24'h333333);
        send(L, L, -1);                                                 // ey == V_ACT
        build(8'hFF, 16'd5, 16'd5, 16'd6, 16'd6, 24'h444444);
        send(L, L, -1);                                                 // clear all enables
        build(8'd0, 16'd7, 16'd8, 16'd9, 16'd10, 24'hABCDEF);
        send(L, L, 5);                                                  // reset mid-packet
        build(8'd1, 16'd11, 16'd12, 16'd13, 16'd14, 24'h010203);
        send(L, L, -1);
`ifdef BOX_CMD_CHECKSUM_EN
        build(8'd0, 16'd21, 16'd22, 16'd23, 16'd24, 24'h0A0B0C);
        pkt[13] = pkt[13] ^ 8'h01;
        send(L, L, -1);
        build(8'd0, 16'd21, 16'd22, 16'd23, 16'd24, 24'h0A0B0C);
        send(L, L, -1);
`endif

        repeat (10) @(negedge clk);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
